mem_port_arbiter: RTL and testbench

- Shares the single-port 8-bit x 8K memory between two requesters:
  - Requester 0: CPU multi-cycle controller (fetch/data).
  - Requester 1: loader/debug DMA port.
- Sits between both requesters and the memory's inData/address/writeEn/outData pins.
- Round-robin arbitration, single-beat transactions, with an optional lock that keeps multi-byte sequences atomic.
- All memory-side drives and responses are registered.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port 8-bit memory between a CPU port (0) and a DMA port (1).
// Optional requester-1 write protect below WP_LIMIT is compiled in with `define MEM_ARB_WP_EN.
module mem_port_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int WP_LIMIT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    output logic              memWriteEn,
    input  logic [DATA_W-1:0] memRdData,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [DATA_W-1:0]   memWrData_q, memWrData_d;
    logic                memWriteEn_q, memWriteEn_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                owner_q, owner_d;
    logic                lastOwner_q, lastOwner_d;
    logic                lockValid_q, lockValid_d;
    logic                lockOwner_q, lockOwner_d;
    logic                elig0, elig1, winner;

`ifdef MEM_ARB_WP_EN
    localparam logic [ADDR_W-1:0] WP_ADDR = ADDR_W'(WP_LIMIT);
    logic wpHit_q, wpHit_d;
    logic err1_q, err1_d;
`endif

    always_comb begin
        state_d      = state_q;
        memAddr_d    = memAddr_q;
        memWrData_d  = memWrData_q;
        memWriteEn_d = memWriteEn_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        owner_d      = owner_q;
        lastOwner_d  = lastOwner_q;
        lockValid_d  = lockValid_q;
        lockOwner_d  = lockOwner_q;
`ifdef MEM_ARB_WP_EN
        wpHit_d      = wpHit_q;
        err1_d       = err1_q;
`endif
        // A held lock masks the non-owner out of arbitration entirely.
        elig0  = req0 && (!lockValid_q || !lockOwner_q);
        elig1  = req1 && (!lockValid_q ||  lockOwner_q);
        winner = (elig0 && elig1) ? ~lastOwner_q : elig1;

        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    owner_d      = winner;
                    memAddr_d    = winner ? addr1  : addr0;
                    memWrData_d  = winner ? wdata1 : wdata0;
                    memWriteEn_d = winner ? we1    : we0;
`ifdef MEM_ARB_WP_EN
                    wpHit_d = winner && we1 && (addr1 < WP_ADDR);
                    if (wpHit_d) begin
                        memWriteEn_d = 1'b0;
                    end
`endif
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (owner_q) begin
                    rdata1_d = memRdData;
                    ack1_d   = 1'b1;
`ifdef MEM_ARB_WP_EN
                    err1_d   = wpHit_q;
`endif
                end else begin
                    rdata0_d = memRdData;
                    ack0_d   = 1'b1;
                end
                memWriteEn_d = 1'b0;
                lastOwner_d  = owner_q;
                lockValid_d  = owner_q ? lock1 : lock0;
                lockOwner_d  = owner_q;
                state_d      = S_RESP;
            end
            S_RESP: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
`ifdef MEM_ARB_WP_EN
                err1_d  = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            memAddr_q    <= '0;
            memWrData_q  <= '0;
            memWriteEn_q <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            owner_q      <= 1'b0;
            lastOwner_q  <= 1'b1;
            lockValid_q  <= 1'b0;
            lockOwner_q  <= 1'b0;
`ifdef MEM_ARB_WP_EN
            wpHit_q      <= 1'b0;
            err1_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            memAddr_q    <= memAddr_d;
            memWrData_q  <= memWrData_d;
            memWriteEn_q <= memWriteEn_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            owner_q      <= owner_d;
            lastOwner_q  <= lastOwner_d;
            lockValid_q  <= lockValid_d;
            lockOwner_q  <= lockOwner_d;
`ifdef MEM_ARB_WP_EN
            wpHit_q      <= wpHit_d;
            err1_q       <= err1_d;
`endif
        end
    end

    assign memAddr    = memAddr_q;
    assign memWrData  = memWrData_q;
    assign memWriteEn = memWriteEn_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign busy       = (state_q == S_ACCESS) || (state_q == S_RESP);
`ifdef MEM_ARB_WP_EN
    assign err1       = err1_q;
`else
    assign err1       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus a behavioural 8K x 8 memory.
// Honours `define MEM_ARB_WP_EN the same way as the design.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, mem_init;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [12:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1, err1, memWriteEn, busy;
    logic [7:0]  rdata0, rdata1, memWrData, memRdData;
    logic [12:0] memAddr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .WP_LIMIT(1000)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .memAddr(memAddr), .memWrData(memWrData), .memWriteEn(memWriteEn),
        .memRdData(memRdData), .busy(busy)
    );

    function automatic logic [7:0] init_val(input logic [12:0] a);
        return (a == 13'd1000) ? 8'h1A : (a[7:0] ^ 8'hA5);
    endfunction

    // Memory device: combinational read, writes ignored while rst is high.
    logic [7:0] dev_mem [0:8191];
    assign memRdData = dev_mem[memAddr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) dev_mem[i] <= init_val(13'(i));
        end else if (memWriteEn && !rst) begin
            dev_mem[memAddr] <= memWrData;
        end
    end

    int n_total = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;

    // Reference model state
    logic [7:0]  ref_mem [0:8191];
    bit          pend, m_own, m_we, m_wp, m_last, m_lv, m_lo;
    int          g, nf;
    logic [12:0] m_addr, x_addr;
    logic [7:0]  m_wdata, x_wdata, x_rd0, x_rd1;
    bit          x_err, done0, done1, ack1_seen;

    function automatic bit wp_rule(input bit own, input bit w, input logic [12:0] a);
`ifdef MEM_ARB_WP_EN
        return own && w && (a < 13'd1000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock, update the model with the inputs sampled at that edge, compare outputs.
    task automatic step();
        bit e0, e1;
        int ph;
        @(posedge clk);
        cyc++;
        done0 = 1'b0;
        done1 = 1'b0;
        if (rst) begin
            pend = 1'b0; nf = cyc + 1; m_last = 1'b1; m_lv = 1'b0; m_lo = 1'b0;
            x_addr = '0; x_wdata = '0; x_rd0 = '0; x_rd1 = '0; x_err = 1'b0;
            if (mem_init) for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(13'(i));
        end else begin
            if (pend && cyc == g + 1) begin
                if (m_own) x_rd1 = ref_mem[m_addr]; else x_rd0 = ref_mem[m_addr];
                x_err = m_wp;
                if (m_we && !m_wp) ref_mem[m_addr] = m_wdata;
                m_last = m_own;
                m_lv   = m_own ? lock1 : lock0;
                m_lo   = m_own;
            end
            if (pend && cyc == g + 2) begin
                pend = 1'b0;
                x_err = 1'b0;
                if (m_own) done1 = 1'b1; else done0 = 1'b1;
            end
            if (cyc >= nf) begin
                e0 = req0 && (!m_lv || !m_lo);
                e1 = req1 && (!m_lv ||  m_lo);
                if (e0 || e1) begin
                    m_own   = (e0 && e1) ? !m_last : e1;
                    m_we    = m_own ? we1 : we0;
                    m_addr  = m_own ? addr1 : addr0;
                    m_wdata = m_own ? wdata1 : wdata0;
                    m_wp    = wp_rule(m_own, m_we, m_addr);
                    x_addr  = m_addr;
                    x_wdata = m_wdata;
                    pend = 1'b1; g = cyc; nf = cyc + 3;
                end
            end
        end
        #1;
        ph = pend ? (cyc - g) : -1;
        if (ack1) ack1_seen = 1'b1;
        check("ack0",       32'(ack0),       32'(ph == 1 && !m_own));
        check("ack1",       32'(ack1),       32'(ph == 1 &&  m_own));
        check("err1",       32'(err1),       32'(ph == 1 && x_err));
        check("busy",       32'(busy),       32'(ph == 0 || ph == 1));
        check("memWriteEn", 32'(memWriteEn), 32'(ph == 0 && m_we && !m_wp));
        check("memAddr",    32'(memAddr),    32'(x_addr));
        check("memWrData",  32'(memWrData),  32'(x_wdata));
        check("rdata0",     32'(rdata0),     32'(x_rd0));
        check("rdata1",     32'(rdata1),     32'(x_rd1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input bit k, input bit r, input bit w, input logic [12:0] a,
                         input logic [7:0] d, input bit lk);
        if (k) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = lk; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = lk; end
    endtask

    task automatic wait_ack(input bit k);
        int n = 0;
        while (!(k ? ack1 : ack0) && n < 40) begin
            step();
            n++;
        end
        check(k ? "ack1_arrival" : "ack0_arrival", 32'(k ? ack1 : ack0), 32'd1);
    endtask

    // Single transaction: hold through the ack cycle, then drop req.
    task automatic do_xfer(input bit k, input bit w, input logic [12:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic er);
        drive(k, 1'b1, w, a, d, 1'b0);
        wait_ack(k);
        rd = k ? rdata1 : rdata0;
        er = err1;
        step();
        drive(k, 1'b0, 1'b0, a, d, 1'b0);
    endtask

    task automatic roll(input bit k);
        logic [12:0] a;
        if ($urandom_range(0, 3) == 0) begin
            drive(k, 1'b0, 1'b0, '0, '0, 1'b0);
        end else begin
            a = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(990, 1009)) : 13'($urandom_range(0, 7));
            drive(k, 1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         c0, cp;

        rst = 1'b1; mem_init = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step();
        mem_init = 1'b0;
        do_reset();

        // Plan 1: single read, two-cycle latency
        c0 = cyc;
        drive(1'b0, 1'b1, 1'b0, 13'd1000, 8'h00, 1'b0);
        wait_ack(1'b0);
        check("t1_latency", 32'(cyc - c0), 32'd2);
        check("t1_rdata0", 32'(rdata0), 32'h1A);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step();

        // Plan 2: simultaneous requests alternate starting with requester 0
        do_reset();
        c0 = cyc;
        drive(1'b0, 1'b1, 1'b0, 13'd3, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 13'd4, 8'h00, 1'b0);
        wait_ack(1'b0);
        check("t2_first_latency", 32'(cyc - c0), 32'd2);
        for (int i = 1; i < 5; i++) begin
            cp = cyc;
            wait_ack(1'(i % 2));
            check("t2_spacing", 32'(cyc - cp), 32'd3);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step();

        // Plan 3: requester 1 write then requester 0 read-back
        do_xfer(1'b1, 1'b1, 13'd1009, 8'h55, rd, er);
        do_xfer(1'b0, 1'b0, 13'd1009, 8'h00, rd, er);
        check("t3_readback", 32'(rd), 32'h55);

        // Plan 4: locked sequence keeps requester 1 out
        do_reset();
        ack1_seen = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 13'd7, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 13'(i), 8'h00, (i < 3));
            wait_ack(1'b0);
            step();
        end
        check("t4_no_ack1_during_lock", 32'(ack1_seen), 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        wait_ack(1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step();

        // Plan 5: reset during the ACCESS cycle of a write
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 13'd1005, 8'hEE, 1'b0);
        step();
        check("t5_granted", 32'(busy), 32'd1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step();
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ack1", 32'(ack1), 32'd0);
        check("t5_we", 32'(memWriteEn), 32'd0);
        step();
        check("t5_no_late_ack1", 32'(ack1), 32'd0);
        do_xfer(1'b0, 1'b0, 13'd1005, 8'h00, rd, er);
        check("t5_mem_unchanged", 32'(rd), 32'h48);

        // Plan 6: write protect boundary
        do_xfer(1'b1, 1'b1, 13'd36, 8'h77, rd, er);
`ifdef MEM_ARB_WP_EN
        check("t6_err_low_addr", 32'(er), 32'd1);
        do_xfer(1'b0, 1'b0, 13'd36, 8'h00, rd, er);
        check("t6_mem36", 32'(rd), 32'h81);
`else
        check("t6_err_low_addr", 32'(er), 32'd0);
        do_xfer(1'b0, 1'b0, 13'd36, 8'h00, rd, er);
        check("t6_mem36", 32'(rd), 32'h77);
`endif
        do_xfer(1'b1, 1'b1, 13'd1000, 8'h3C, rd, er);
        check("t6_err_limit", 32'(er), 32'd0);
        do_xfer(1'b0, 1'b0, 13'd1000, 8'h00, rd, er);
        check("t6_mem1000", 32'(rd), 32'h3C);

        // Randomized traffic from both requesters against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step();
            if (done0 || (!req0 && $urandom_range(0, 2) == 0)) roll(1'b0);
            if (done1 || (!req1 && $urandom_range(0, 2) == 0)) roll(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
